// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, function codes,
// ALU control values, FSM states and datapath select types.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int unsigned RESET_PC_DEFAULT = 0;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_BOFF} srcb_t;
  typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP} pcsrc_t;

  function automatic logic func_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [2:0] func_to_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_if.sv
// Unified instruction/data memory port; the core drives it as master.
interface mips_multicycle_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle FSM: sequences the datapath and owns the registered bus outputs.
// Define MIPS_BNE_EN to decode opcode 0x05 as bne instead of halting.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       halted_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output pcsrc_t     pc_src_o,
  output logic       ab_we_o,
  output logic       alu_we_o,
  output logic       alu_srca_o,
  output srcb_t      alu_srcb_o,
  output logic [2:0] alu_ctl_o,
  output logic       mdr_we_o,
  output logic       rf_we_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o
);

  state_t state_q, state_d;
  logic   req_q, we_q, iord_q, halted_q;
  logic   mem_done, br_taken;

  // A request only completes while it is actually on the bus.
  assign mem_done = req_q & mem_ready_i;

  always_comb begin
    br_taken = zero_i;
`ifdef MIPS_BNE_EN
    if (opcode_i == OP_BNE) br_taken = ~zero_i;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_ADDI:         state_d = S_EXEC_I;
          OP_BEQ:          state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
          OP_BNE:          state_d = S_BRANCH;
`endif
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_HALT;
        endcase
      end
      S_EXEC_R:   state_d = func_legal(func_i) ? S_WB_R : S_HALT;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_done) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_done) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_HALT;
    endcase
  end

  // Bus outputs are registered from the next state so they are valid from
  // the first cycle of a memory state and hold until it is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      iord_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= (state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      we_q     <= (state_d == S_MEM_WR);
      iord_q   <= (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      halted_q <= (state_d == S_HALT);
    end
  end

  assign mem_req_o = req_q;
  assign mem_we_o  = we_q;
  assign iord_o    = iord_q;
  assign halted_o  = halted_q;

  always_comb begin
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = PCSRC_ALU;
    ab_we_o      = 1'b0;
    alu_we_o     = 1'b0;
    alu_srca_o   = 1'b1;
    alu_srcb_o   = SRCB_B;
    alu_ctl_o    = ALU_ADD;
    mdr_we_o     = 1'b0;
    rf_we_o      = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we_o    = mem_done;
        pc_we_o    = mem_done;
        alu_srca_o = 1'b0;
        alu_srcb_o = SRCB_FOUR;
      end
      S_DECODE: begin
        ab_we_o    = 1'b1;
        alu_we_o   = 1'b1;
        alu_srca_o = 1'b0;
        alu_srcb_o = SRCB_BOFF;
      end
      S_EXEC_R: begin
        alu_we_o  = func_legal(func_i);
        alu_ctl_o = func_to_alu(func_i);
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_we_o   = 1'b1;
        alu_srcb_o = SRCB_IMM;
      end
      S_MEM_RD: mdr_we_o = mem_done;
      S_WB_R: begin
        rf_we_o   = 1'b1;
        reg_dst_o = 1'b1;
      end
      S_WB_I:   rf_we_o = 1'b1;
      S_WB_MEM: begin
        rf_we_o      = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_BRANCH: begin
        pc_we_o  = br_taken;
        pc_src_o = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_we_o  = 1'b1;
        pc_src_o = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: shared ALU, unified memory port, FSM in mips_mc_control.
// Define MIPS_BNE_EN to enable the bne instruction (opcode 0x05).
module mips_multicycle
  import mips_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_multicycle_if.master     mem,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, jump_tgt;
  logic [31:0]           ir_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, alu_q, mdr_q;
  logic [DATA_WIDTH-1:0] rf_q [32];
  logic [DATA_WIDTH-1:0] srca, srcb, alu_res, imm_sx, wb_data;
  logic [4:0]            rs, rt, rd, wr_reg;

  logic       mem_req, mem_we, iord;
  logic       ir_we, pc_we, ab_we, alu_we, alu_srca, mdr_we, rf_we, reg_dst, mem_to_reg;
  pcsrc_t     pc_src;
  srcb_t      alu_srcb;
  logic [2:0] alu_ctl;

  function automatic logic [DATA_WIDTH-1:0] alu_op(input logic [2:0] ctl,
                                                   input logic [DATA_WIDTH-1:0] x,
                                                   input logic [DATA_WIDTH-1:0] y);
    case (ctl)
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SUB: return x - y;
      ALU_SLT: return {{(DATA_WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: return x + y;
    endcase
  endfunction

  mips_mc_control u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .opcode_i     (ir_q[31:26]),
    .func_i       (ir_q[5:0]),
    .mem_ready_i  (mem.mem_ready),
    .zero_i       (a_q == b_q),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .iord_o       (iord),
    .halted_o     (halted),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .pc_src_o     (pc_src),
    .ab_we_o      (ab_we),
    .alu_we_o     (alu_we),
    .alu_srca_o   (alu_srca),
    .alu_srcb_o   (alu_srcb),
    .alu_ctl_o    (alu_ctl),
    .mdr_we_o     (mdr_we),
    .rf_we_o      (rf_we),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg)
  );

  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign imm_sx = {{(DATA_WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign wr_reg = reg_dst ? rd : rt;
  assign wb_data = mem_to_reg ? mdr_q : alu_q;

  assign srca = alu_srca ? a_q : DATA_WIDTH'(pc_q);

  always_comb begin
    case (alu_srcb)
      SRCB_FOUR: srcb = DATA_WIDTH'(4);
      SRCB_IMM:  srcb = imm_sx;
      SRCB_BOFF: srcb = imm_sx << 2;
      default:   srcb = b_q;
    endcase
  end

  assign alu_res = alu_op(alu_ctl, srca, srcb);

  // Jump keeps the upper PC bits of the already-incremented PC.
  always_comb begin
    jump_tgt       = pc_q;
    jump_tgt[27:0] = {ir_q[25:0], 2'b00};
  end

  always_comb begin
    case (pc_src)
      PCSRC_ALUOUT: pc_d = ADDR_WIDTH'(alu_q);
      PCSRC_JUMP:   pc_d = jump_tgt;
      default:      pc_d = ADDR_WIDTH'(alu_res);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= PC_RST;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (pc_we)  pc_q  <= pc_d;
      if (ir_we)  ir_q  <= mem.mem_rdata[31:0];
      if (ab_we) begin
        a_q <= rf_q[rs];
        b_q <= rf_q[rt];
      end
      if (alu_we) alu_q <= alu_res;
      if (mdr_we) mdr_q <= mem.mem_rdata;
      if (rf_we && (wr_reg != 5'd0)) rf_q[wr_reg] <= wb_data;
    end
  end

  assign mem.mem_req   = mem_req;
  assign mem.mem_we    = mem_we;
  assign mem.mem_addr  = iord ? ADDR_WIDTH'(alu_q) : pc_q;
  assign mem.mem_wdata = b_q;
  assign pc_out        = pc_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed program bench for mips_multicycle with a bus scoreboard.
module tb_mips_multicycle;
  import mips_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [31:0] pc_out;
  logic [31:0] mem [1024];
  int          wcnt;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  txn_t        exp_q[$];

  mips_multicycle_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mips_multicycle #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h100)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem    (bus.master),
    .halted (halted),
    .pc_out (pc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Data reads at 0x200.. take 3 wait states; anything at 0x300.. stalls long.
  function automatic int waits(input logic [31:0] a, input logic we);
    if (a >= 32'h300) return 100;
    if (!we && a >= 32'h200) return 3;
    return 0;
  endfunction

  assign bus.mem_ready = bus.mem_req && (wcnt >= waits(bus.mem_addr, bus.mem_we));
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk)
    if (!rst && bus.mem_req && bus.mem_we && bus.mem_ready)
      mem[bus.mem_addr[11:2]] <= bus.mem_wdata;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int tgt);
    return {OP_J, 26'(tgt)};
  endfunction

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data; t.gap = gap;
    exp_q.push_back(t);
  endtask

  // Monitor: compares every completed bus transfer against the expected queue
  // and checks that a stalled request holds its address/control/data.
  logic        held_v = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic        held_we;
  int          last_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else if (bus.mem_req) begin
      if (held_v) begin
        chk(bus.mem_addr == held_addr, "stall_addr", bus.mem_addr, held_addr);
        chk(bus.mem_we == held_we, "stall_we", 32'(bus.mem_we), 32'(held_we));
        chk(bus.mem_wdata == held_wdata, "stall_wdata", bus.mem_wdata, held_wdata);
      end
      if (bus.mem_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_txn", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          chk(bus.mem_addr == t.addr, "txn_addr", bus.mem_addr, t.addr);
          chk(bus.mem_we == t.we, "txn_we", 32'(bus.mem_we), 32'(t.we));
          if (t.we) chk(bus.mem_wdata == t.data, "txn_wdata", bus.mem_wdata, t.data);
          if (t.gap >= 0) chk((cyc - last_cyc) == t.gap, "txn_gap", 32'(cyc - last_cyc), 32'(t.gap));
        end
        last_cyc = cyc;
        held_v   = 1'b0;
      end else if (!held_v) begin
        held_v     = 1'b1;
        held_addr  = bus.mem_addr;
        held_we    = bus.mem_we;
        held_wdata = bus.mem_wdata;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_halted_quiet();
    int reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_req) reqs++;
    end
    chk(halted == 1'b1, "halted", 32'(halted), 32'd1);
    chk(reqs == 0, "halt_no_req", 32'(reqs), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(bus.mem_req == 1'b0, {tag, "_req"}, 32'(bus.mem_req), 32'd0);
    chk(bus.mem_we == 1'b0, {tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk(bus.mem_addr == 32'h100, {tag, "_addr"}, bus.mem_addr, 32'h100);
    chk(halted == 1'b0, {tag, "_halted"}, 32'(halted), 32'd0);
    chk(pc_out == 32'h100, {tag, "_pc"}, pc_out, 32'h100);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem['h100 >> 2] = enc_j(0);
    mem['h000 >> 2] = enc_i(OP_ADDI, 0, 1, 5);
    mem['h004 >> 2] = enc_i(OP_ADDI, 0, 2, 7);
    mem['h008 >> 2] = enc_r(1, 2, 3, FN_ADD);
    mem['h00C >> 2] = enc_i(OP_SW, 0, 3, 'h200);
    mem['h010 >> 2] = enc_i(OP_BEQ, 1, 1, 2);
    mem['h014 >> 2] = 32'hFC00_0000;
    mem['h018 >> 2] = 32'hFC00_0000;
    mem['h01C >> 2] = enc_i(OP_BEQ, 1, 2, 5);
    mem['h020 >> 2] = enc_i(OP_LW, 0, 4, 'h200);
    mem['h024 >> 2] = enc_i(OP_ADDI, 0, 0, 9);
    mem['h028 >> 2] = enc_r(0, 0, 5, FN_ADD);
    mem['h02C >> 2] = enc_i(OP_ADDI, 0, 6, -1);
    mem['h030 >> 2] = enc_i(OP_ADDI, 0, 7, 1);
    mem['h034 >> 2] = enc_r(6, 7, 8, FN_SLT);
    mem['h038 >> 2] = enc_r(1, 2, 9, FN_SUB);
    mem['h03C >> 2] = enc_r(3, 2, 10, FN_AND);
    mem['h040 >> 2] = enc_r(3, 1, 11, FN_OR);
    mem['h044 >> 2] = enc_i(OP_SW, 0, 4, 'h204);
    mem['h048 >> 2] = enc_i(OP_SW, 0, 5, 'h208);
    mem['h04C >> 2] = enc_i(OP_SW, 0, 8, 'h20C);
    mem['h050 >> 2] = enc_i(OP_SW, 0, 9, 'h210);
    mem['h054 >> 2] = enc_i(OP_SW, 0, 10, 'h214);
    mem['h058 >> 2] = enc_i(OP_SW, 0, 11, 'h218);
    mem['h05C >> 2] = enc_j('h30);
    mem['h0C0 >> 2] = enc_i(OP_BNE, 1, 2, 2);
    mem['h0C4 >> 2] = enc_i(OP_ADDI, 0, 1, 1);
    mem['h0CC >> 2] = 32'hFC00_0000;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    push(0, 32'h100, 0, -1);
    push(0, 32'h000, 0, 3);
    push(0, 32'h004, 0, 4);
    push(0, 32'h008, 0, 4);
    push(0, 32'h00C, 0, 4);
    push(1, 32'h200, 32'd12, 3);
    push(0, 32'h010, 0, 1);
    push(0, 32'h01C, 0, 3);
    push(0, 32'h020, 0, 3);
    push(0, 32'h200, 0, 6);
    push(0, 32'h024, 0, 2);
    push(0, 32'h028, 0, 4);
    push(0, 32'h02C, 0, 4);
    push(0, 32'h030, 0, 4);
    push(0, 32'h034, 0, 4);
    push(0, 32'h038, 0, 4);
    push(0, 32'h03C, 0, 4);
    push(0, 32'h040, 0, 4);
    push(0, 32'h044, 0, 4);
    push(1, 32'h204, 32'd12, 3);
    push(0, 32'h048, 0, 1);
    push(1, 32'h208, 32'd0, 3);
    push(0, 32'h04C, 0, 1);
    push(1, 32'h20C, 32'd1, 3);
    push(0, 32'h050, 0, 1);
    push(1, 32'h210, 32'hFFFF_FFFE, 3);
    push(0, 32'h054, 0, 1);
    push(1, 32'h214, 32'd4, 3);
    push(0, 32'h058, 0, 1);
    push(1, 32'h218, 32'd13, 3);
    push(0, 32'h05C, 0, 1);
    push(0, 32'h0C0, 0, 3);
`ifdef MIPS_BNE_EN
    push(0, 32'h0CC, 0, 3);
`endif

    @(negedge clk);
    rst = 1'b0;
    drain(2000);
    check_halted_quiet();

    // Second run: reset in the middle of a stalled store.
    @(negedge clk);
    rst = 1'b1;
    mem['h100 >> 2] = enc_i(OP_SW, 0, 0, 'h300);
    mem['h300 >> 2] = 32'hDEAD_BEEF;
    @(negedge clk);
    push(0, 32'h100, 0, -1);
    rst = 1'b0;
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(bus.mem_req && bus.mem_we, "reach_mem_wr", 32'(n), 32'd5);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    drain(10);
    repeat (2) @(posedge clk);
    #1;
    chk(mem['h300 >> 2] == 32'hDEAD_BEEF, "abandoned_write", mem['h300 >> 2], 32'hDEAD_BEEF);
    mem['h100 >> 2] = 32'hFC00_0000;
    push(0, 32'h100, 0, -1);
    @(negedge clk);
    rst = 1'b0;
    drain(100);
    check_halted_quiet();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Multicycle successor to the single-cycle MIPS core: one FSM-sequenced datapath, one shared ALU, one unified instruction/data memory port with a req/ready handshake.
- Adds beq, addi, wait-state tolerance and an illegal-opcode halt.
- Top-level core instantiated by the SoC/testbench. Existing reg_file and alu blocks are reused inside it.

Parameters:
DATA_WIDTH, 32, register/ALU/memory data width (≥32; instruction word fixed at 32 bits, zero-extended/truncated into datapath)
ADDR_WIDTH, 32, byte address width of memory port
RESET_PC, 0, PC value loaded at reset (word aligned)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
mem_req  output  1  memory request valid
mem_we  output  1  1=write, 0=read (valid when mem_req)
mem_addr  output  ADDR_WIDTH  byte address
mem_wdata  output  DATA_WIDTH  store data
mem_rdata  input  DATA_WIDTH  read data, valid in the cycle mem_ready=1
mem_ready  input  1  request accepted/completed this cycle
halted  output  1  core stopped on illegal opcode
pc_out  output  ADDR_WIDTH  current PC (debug)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On rst=1: state=FETCH, pc=RESET_PC, IR/A/B/ALUOut/MDR=0, all registers=0. Outputs: mem_req=0, mem_we=0, halted=0, mem_addr=RESET_PC. Reset mid-transaction abandons the request with no writes.
- Handshake: mem_req, mem_we, mem_addr and mem_wdata are held stable from the first cycle of a memory state until mem_ready=1. Zero-wait memory (mem_ready combinationally 1) is legal. The FSM leaves a memory state only on mem_ready=1.
- States and transitions:
  - FETCH: req read @pc. On ready: IR<=rdata[31:0], pc<=pc+4 (wraps modulo 2^ADDR_WIDTH) -> DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=pc+(sext(imm)<<2). Next state by opcode: R(0x00)->EXEC_R; lw(0x23)/sw(0x2B)/addi(0x08)->MEM_ADDR/MEM_ADDR/EXEC_I; beq(0x04)->BRANCH; j(0x02)->JUMP; other->HALT.
  - EXEC_R: ALUOut<=A op B. func 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Other func -> HALT. Else -> WB_R.
  - EXEC_I: ALUOut<=A+sext(imm) -> WB_I.
  - MEM_ADDR: ALUOut<=A+sext(imm) -> MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: req read @ALUOut; on ready MDR<=rdata -> WB_MEM.
  - MEM_WR: req write @ALUOut, wdata=B; on ready -> FETCH.
  - WB_R: rf[rd]<=ALUOut. WB_I: rf[rt]<=ALUOut. WB_MEM: rf[rt]<=MDR. All -> FETCH.
  - BRANCH: if A==B, pc<=ALUOut -> FETCH.
  - JUMP: pc<={pc[ADDR_WIDTH-1:28], target, 2'b00} -> FETCH.
  - HALT: terminal until reset. halted=1, mem_req=0, no register writes.
- Arithmetic: 32-bit wrap-around, no overflow exceptions. Writes to register 0 are discarded; it always reads 0.
- CPI with zero-wait memory: R/addi=4, lw=5, sw=4, beq=3, j=3. Each wait cycle on a memory access adds 1.
- Address alignment is not checked; low two address bits are driven as computed.

Optional Feature:
- MIPS_BNE_EN defined: opcode 0x05 (bne) decodes to BRANCH with inverted compare (taken if A!=B), 3 cycles.
- Undefined: 0x05 is illegal -> HALT.

Decomposition:
- Package mips_pkg: opcode and func localparams, state_t enum, alu_control 3-bit encodings (shared with alu_control/alu), RESET_PC default.
- Sub-module mips_mc_control: the FSM. Inputs opcode, func, mem_ready, zero. Outputs all datapath enables/selects plus halted.
- Datapath stays in mips_multicycle.

Test Plan:
- Reset: rst pulse, RESET_PC=0x100 -> first mem_req read @0x100, halted=0, pc_out=0x100.
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,8($0); zero-wait -> write @0x8 data 12; total 4+4+4+4=16 cycles.
- lw $4,8($0) with mem_ready delayed 3 cycles -> mem_req/addr stable for 4 cycles, $4=12, instruction takes 8 cycles.
- beq $1,$1,+2 at 0x10 -> next fetch @0x1C. beq $1,$2 not taken -> fetch @0x14. j 0x40 -> fetch @0x100.
- addi $0,$0,9 then add $5,$0,$0 -> $5=0. slt of 0xFFFFFFFF vs 1 -> 1.
- Opcode 0x3F -> halted=1, no further mem_req. Opcode 0x05 halts without MIPS_BNE_EN, branches with it. Async rst mid-MEM_WR -> no write completes, restart at RESET_PC.
